axi_dmem_slave: RTL and testbench

AXI_DMEM_SLAVE -- requirements
Module: axi_dmem_slave

---
 rtl/axi_dmem_slave.sv | 123 ++++++++++++
 tb/tb_axi_dmem_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dmem_slave.sv
// axi_dmem_slave: AXI4-Lite word-addressed data memory, one outstanding read and one outstanding write
module axi_dmem_slave #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] LP_DEPTH = 30'(DEPTH_WORDS);
  localparam logic [0:0]  R_IDLE   = 1'b0;
  localparam logic [0:0]  R_DATA   = 1'b1;
  localparam logic [1:0]  W_IDLE   = 2'd0;
  localparam logic [1:0]  W_COMMIT = 2'd1;
  localparam logic [1:0]  W_RESP   = 2'd2;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [0:0]  r_rstate;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [1:0]  r_wstate;
  logic        r_aw_got;
  logic        r_w_got;
  logic [29:0] r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;

  logic [29:0] w_ar_idx;
  logic        w_ar_ok;
  logic        w_aw_ok;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_have;
  logic        w_w_have;
  logic        w_unused;

  assign w_ar_idx    = axi_araddr[31:2];
  assign w_ar_ok     = w_ar_idx < LP_DEPTH;
  assign w_aw_ok     = r_aw_idx < LP_DEPTH;
  assign axi_arready = r_rstate == R_IDLE;
  assign axi_rvalid  = r_rstate == R_DATA;
  assign axi_rdata   = r_rdata;
  assign axi_rresp   = r_rresp;
  assign axi_awready = (r_wstate == W_IDLE) & ~r_aw_got;
  assign axi_wready  = (r_wstate == W_IDLE) & ~r_w_got;
  assign axi_bvalid  = r_wstate == W_RESP;
  assign axi_bresp   = r_bresp;
  assign w_aw_hs     = axi_awvalid & axi_awready;
  assign w_w_hs      = axi_wvalid & axi_wready;
  assign w_aw_have   = r_aw_got | w_aw_hs;
  assign w_w_have    = r_w_got | w_w_hs;
  assign w_unused    = ^{axi_arprot, axi_awprot, axi_araddr[1:0], axi_awaddr[1:0]};

  // Read path: data is registered on the AR handshake, giving a fixed 1-cycle latency
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else if (r_rstate == R_IDLE) begin
      if (axi_arvalid) begin
        r_rstate <= R_DATA;
        r_rdata  <= w_ar_ok ? r_mem[w_ar_idx[AW-1:0]] : '0;
        r_rresp  <= w_ar_ok ? 2'b00 : 2'b10;
      end
    end else if (axi_rready)
      r_rstate <= R_IDLE;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wstate <= W_IDLE;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_aw_idx <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= '0;
    end else begin
      if (w_aw_hs) r_aw_idx <= axi_awaddr[31:2];
      if (w_w_hs) begin
        r_wdata <= axi_wdata;
        r_wstrb <= axi_wstrb;
      end
      case (r_wstate)
        W_IDLE: begin
          r_aw_got <= w_aw_have & ~w_w_have;
          r_w_got  <= w_w_have & ~w_aw_have;
          if (w_aw_have & w_w_have) r_wstate <= W_COMMIT;
        end
        W_COMMIT: begin
          r_wstate <= W_RESP;
          r_bresp  <= w_aw_ok ? 2'b00 : 2'b10;
        end
        W_RESP: if (axi_bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end

  // Memory is never reset; a reset before the commit cycle leaves it untouched
  always_ff @(posedge clk)
    if (r_wstate == W_COMMIT && w_aw_ok)
      for (int i = 0; i < 4; i++)
        if (r_wstrb[i]) r_mem[r_aw_idx[AW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
endmodule

// File: tb/tb_axi_dmem_slave.sv
// tb_axi_dmem_slave: directed and randomized AXI4-Lite traffic checked against a byte-level memory model
module tb_axi_dmem_slave;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [2:0]  axi_arprot = '0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [2:0]  axi_awprot = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] mb [DEPTH][4];
  bit         kn [DEPTH][4];

  always #5 clk = ~clk;

  axi_dmem_slave #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [31:0] a, output logic [31:0] e, output logic [31:0] m, output logic [1:0] r);
    int idx = int'(a[31:2]);
    e = '0;
    m = '1;
    r = 2'b10;
    if (idx < DEPTH) begin
      r = 2'b00;
      for (int i = 0; i < 4; i++) begin
        e[8*i +: 8] = mb[idx][i];
        m[8*i +: 8] = kn[idx][i] ? 8'hFF : 8'h00;
      end
    end
  endtask

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[31:2]);
    if (idx < DEPTH)
      for (int i = 0; i < 4; i++)
        if (s[i]) begin
          mb[idx][i] = d[8*i +: 8];
          kn[idx][i] = 1'b1;
        end
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, input string tag, output logic [31:0] rd);
    logic [31:0] e, m;
    logic [1:0]  r;
    exp_word(a, e, m, r);
    axi_araddr = a;
    axi_arvalid = 1'b1;
    axi_rready = 1'b0;
    chk({tag, ".arready_idle"}, 32'(axi_arready), 1);
    tick;
    axi_arvalid = hold > 0;
    rd = axi_rdata;
    chk({tag, ".rvalid_lat1"}, 32'(axi_rvalid), 1);
    chk({tag, ".rdata"}, axi_rdata & m, e & m);
    chk({tag, ".rresp"}, 32'(axi_rresp), 32'(r));
    for (int k = 0; k < hold; k++) begin
      tick;
      chk({tag, ".hold_rvalid"}, 32'(axi_rvalid), 1);
      chk({tag, ".hold_rdata"}, axi_rdata & m, e & m);
      chk({tag, ".hold_arready"}, 32'(axi_arready), 0);
    end
    axi_arvalid = 1'b0;
    axi_rready = 1'b1;
    tick;
    axi_rready = 1'b0;
    chk({tag, ".rvalid_drop"}, 32'(axi_rvalid), 0);
    chk({tag, ".arready_back"}, 32'(axi_arready), 1);
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int hold, input bit rd_commit, input string tag);
    int ta = lead > 0 ? lead : 0;
    int tw = lead < 0 ? -lead : 0;
    int t = 0;
    bit aw_done = 0, w_done = 0, hsa, hsw;
    logic [31:0] oe, om;
    logic [1:0]  oer;
    logic [1:0]  eb = int'(a[31:2]) < DEPTH ? 2'b00 : 2'b10;
    axi_awaddr = a;
    axi_wdata = d;
    axi_wstrb = s;
    while (!(aw_done && w_done) && t < 20) begin
      axi_awvalid = !aw_done && t >= ta;
      axi_wvalid = !w_done && t >= tw;
      hsa = axi_awvalid && axi_awready;
      hsw = axi_wvalid && axi_wready;
      tick;
      t++;
      aw_done |= hsa;
      w_done |= hsw;
      if (w_done && !aw_done) chk({tag, ".wready_low"}, 32'(axi_wready), 0);
      if (aw_done && !w_done) chk({tag, ".awready_low"}, 32'(axi_awready), 0);
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    chk({tag, ".accepted"}, 32'(aw_done && w_done), 1);
    chk({tag, ".commit_bvalid"}, 32'(axi_bvalid), 0);
    chk({tag, ".commit_ready"}, 32'({axi_awready, axi_wready}), 0);
    exp_word(a, oe, om, oer);
    if (rd_commit) begin
      axi_araddr = a;
      axi_arvalid = 1'b1;
    end
    tick;
    mwrite(a, d, s);
    chk({tag, ".bvalid"}, 32'(axi_bvalid), 1);
    chk({tag, ".bresp"}, 32'(axi_bresp), 32'(eb));
    if (rd_commit) begin
      axi_arvalid = 1'b0;
      chk({tag, ".rc_rvalid"}, 32'(axi_rvalid), 1);
      chk({tag, ".rc_old_data"}, axi_rdata & om, oe & om);
      axi_rready = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      tick;
      chk({tag, ".hold_bvalid"}, 32'(axi_bvalid), 1);
      chk({tag, ".hold_bresp"}, 32'(axi_bresp), 32'(eb));
      chk({tag, ".hold_awready"}, 32'(axi_awready), 0);
    end
    axi_bready = 1'b1;
    tick;
    axi_bready = 1'b0;
    axi_rready = 1'b0;
    chk({tag, ".bvalid_drop"}, 32'(axi_bvalid), 0);
    chk({tag, ".ready_back"}, 32'({axi_awready, axi_wready}), 3);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, 32'({axi_arready, axi_awready, axi_wready}), 7);
    chk({tag, ".valid"}, 32'({axi_rvalid, axi_bvalid}), 0);
    chk({tag, ".rdata"}, axi_rdata, 0);
    chk({tag, ".resp"}, 32'({axi_rresp, axi_bresp}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    #2;
    chk_reset_outputs("por");
    #10;
    rstn = 1'b1;
    tick;
    chk_reset_outputs("post_release");

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, "basic_wr");
    do_read(32'h10, 0, "basic_rd", rd);
    chk("basic_const", rd, 32'hDEADBEEF);

    do_write(32'h20, 32'hAAAAAAAA, 4'hF, 0, 0, 0, "pre_wr");
    do_write(32'h20, 32'h11223344, 4'b0101, 3, 0, 0, "w_first");
    do_read(32'h22, 0, "strb_rd", rd);
    chk("strb_const", rd, 32'hAA22AA44);

    do_write(32'h0, 32'h01020304, 4'hF, -2, 0, 0, "w0");
    do_write(32'(DEPTH * 4), 32'h12345678, 4'hF, -2, 0, 0, "oor_wr");
    do_read(32'(DEPTH * 4), 0, "oor_rd", rd);
    do_read(32'h0, 0, "w0_chk", rd);
    chk("w0_const", rd, 32'h01020304);
    do_read(32'h10, 0, "w10_chk", rd);

    do_read(32'h10, 5, "rhold", rd);
    do_write(32'h24, 32'hC0FFEE11, 4'hF, 0, 5, 0, "bhold");

    do_write(32'h30, 32'h0, 4'hF, 0, 0, 0, "rc_init");
    do_write(32'h30, 32'h55, 4'hF, 1, 0, 1, "rc_wr");
    do_read(32'h30, 0, "rc_after", rd);
    chk("rc_const", rd, 32'h55);

    do_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, "strb0");
    do_read(32'h10, 0, "strb0_rd", rd);
    chk("strb0_const", rd, 32'hDEADBEEF);

    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, "rst_init");
    do_write(32'hFFFFFFFC, 32'h0, 4'hF, 0, 0, 0, "oor_hi");
    do_read(32'h10, 0, "rst_pre_rd", rd);
    axi_awaddr = 32'h40;
    axi_awvalid = 1'b1;
    tick;
    axi_awvalid = 1'b0;
    chk("rst.aw_captured", 32'({axi_awready, axi_wready}), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    tick;
    chk("rst.ready_after", 32'({axi_awready, axi_wready}), 3);
    do_read(32'h40, 0, "rst_rd", rd);
    chk("rst_const", rd, 32'hCAFEF00D);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a, d;
      int op;
      a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4) + ($urandom_range(0, 63) << 2) : ($urandom_range(0, 31) << 2);
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      op = int'($urandom_range(0, 2));
      if (op == 0)
        do_read(a, int'($urandom_range(0, 3)), "rnd_rd", rd);
      else
        do_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 3)), op == 2, "rnd_wr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
